// File: rtl/uart_pkg.sv
// Shared widths and FSM state encodings for the UART subsystem.
package uart_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PTR_WIDTH  = 5;
    localparam int ADDR_WIDTH = PTR_WIDTH - 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_VALID
    } rx_state_e;

endpackage

// File: rtl/uart_core.sv
// 8N1 UART transceiver: independent TX shifter and mid-bit sampling RX with a valid/ready output.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    input  logic                  serial_in,
    output logic                  serial_out
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_WIDTH        = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME / 2 - 1);

    tx_state_e             tx_state_q;
    logic [CNT_WIDTH-1:0]  tx_cnt_q;
    logic [2:0]            tx_bit_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            serial_out    <= 1'b1;
            data_in_ready <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (data_in_valid && data_in_ready) begin
                        tx_shift_q    <= data_in;
                        tx_cnt_q      <= '0;
                        serial_out    <= 1'b0;
                        data_in_ready <= 1'b0;
                        tx_state_q    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        serial_out <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            serial_out <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            serial_out <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q      <= '0;
                        data_in_ready <= 1'b1;
                        tx_state_q    <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    rx_state_e             rx_state_q;
    logic [1:0]            rx_sync_q;
    logic                  rx_prev_q;
    logic [CNT_WIDTH-1:0]  rx_cnt_q;
    logic [2:0]            rx_bit_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic                  rx_in;

    // Two-flop synchroniser; its fixed delay shifts every sample point equally.
    assign rx_in = rx_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q     <= RX_IDLE;
            rx_sync_q      <= 2'b11;
            rx_prev_q      <= 1'b1;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], serial_in};
            rx_prev_q <= rx_in;
            if (data_out_valid && data_out_ready) begin
                data_out_valid <= 1'b0;
            end
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_in) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_in, rx_shift_q[DATA_WIDTH-1:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_VALID;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_VALID: begin
                    data_out       <= rx_shift_q;
                    data_out_valid <= 1'b1;
                    rx_state_q     <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// 16x8 synchronous FIFO with wrap-bit pointers; the read data is shown from the head slot.
module uart_fifo
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] fifo_reg [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  push;
    logic                  pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]);

    assign push   = wr_en_i && !full_o;
    assign pop    = rd_en_i && !empty_o;
    assign dout_o = fifo_reg[rd_ptr[ADDR_WIDTH-1:0]];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr[ADDR_WIDTH-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_top.sv
// UART subsystem: received bytes land in the RX FIFO; start_tx drains the TX FIFO onto the line.
module uart_top
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic clk,
    input  logic rst,
    input  logic start_tx,
    input  logic serial_rx,
    output logic serial_tx
);

    logic [DATA_WIDTH-1:0] core_din;
    logic                  core_din_valid;
    logic                  core_din_ready;
    logic [DATA_WIDTH-1:0] core_dout;
    logic                  core_dout_valid;
    logic                  core_dout_ready;

    logic [DATA_WIDTH-1:0] rx_fifo_dout_unused;
    logic                  rx_fifo_full_unused;
    logic                  rx_fifo_empty_unused;

    logic                  tx_wr_en;
    logic [DATA_WIDTH-1:0] tx_wr_data;
    logic [DATA_WIDTH-1:0] tx_fifo_dout;
    logic                  tx_fifo_full_unused;
    logic                  tx_fifo_empty;
    logic                  tx_pop;

    logic                  sending;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;

    uart_core #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) uart_i (
        .clk           (clk),
        .rst           (rst),
        .data_in       (core_din),
        .data_in_valid (core_din_valid),
        .data_in_ready (core_din_ready),
        .data_out      (core_dout),
        .data_out_valid(core_dout_valid),
        .data_out_ready(core_dout_ready),
        .serial_in     (serial_rx),
        .serial_out    (serial_tx)
    );

    // Every received byte is acknowledged at once; a full FIFO simply drops it.
    assign core_dout_ready = core_dout_valid;

    uart_fifo fifo_rx_uart_i (
        .clk    (clk),
        .rst    (rst),
        .wr_en_i(core_dout_valid),
        .din_i  (core_dout),
        .rd_en_i(1'b0),
        .dout_o (rx_fifo_dout_unused),
        .full_o (rx_fifo_full_unused),
        .empty_o(rx_fifo_empty_unused)
    );

    // TX FIFO contents are loaded from outside this block; its write port idles here.
    assign tx_wr_en   = 1'b0;
    assign tx_wr_data = '0;

    uart_fifo fifo_tx_uart_i (
        .clk    (clk),
        .rst    (rst),
        .wr_en_i(tx_wr_en),
        .din_i  (tx_wr_data),
        .rd_en_i(tx_pop),
        .dout_o (tx_fifo_dout),
        .full_o (tx_fifo_full_unused),
        .empty_o(tx_fifo_empty)
    );

    // The valid pulse blocks a second pop while the core has not yet dropped ready.
    assign tx_pop         = sending && !tx_fifo_empty && core_din_ready && !tx_valid_q;
    assign core_din       = tx_data_q;
    assign core_din_valid = tx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sending    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= tx_pop;
            if (tx_pop) begin
                tx_data_q <= tx_fifo_dout;
            end
            if (start_tx) begin
                sending <= 1'b1;
            end else if (tx_fifo_empty) begin
                sending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top: drives and decodes 8N1 frames on the serial pins.
module tb_uart_top;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int SYM      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_tx = 1'b0;
    logic serial_rx = 1'b1;
    logic serial_tx;

    logic       force_en = 1'b0;
    logic [7:0] force_data = 8'h00;

    int errors = 0;
    int checks = 0;
    int rx_valid_cnt = 0;

    uart_top #(
        .CLOCK_FREQ(CLK_FREQ),
        .BAUD_RATE (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_tx (start_tx),
        .serial_rx(serial_rx),
        .serial_tx(serial_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && dut.uart_i.data_out_valid) rx_valid_cnt <= rx_valid_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] rx_vec(input int i);
        return 8'((i * 53 + 7) & 255);
    endfunction

    function automatic logic [7:0] tx_vec(input int i);
        return 8'(((i * 29 + 60) ^ 90) & 255);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start_tx = 1'b0;
        serial_rx = 1'b1;
        force_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_rx_byte(input logic [7:0] b);
        serial_rx = 1'b0;
        repeat (SYM) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (SYM) @(negedge clk);
        end
        serial_rx = 1'b1;
        repeat (SYM + 4) @(negedge clk);
    endtask

    task automatic preload_tx(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            force_en = 1'b1;
            force_data = tx_vec(first + i);
            @(negedge clk);
        end
        force_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_tx = 1'b1;
        @(negedge clk);
        start_tx = 1'b0;
    endtask

    // Waits for a start bit, then samples each bit at its middle; returns at mid stop bit.
    task automatic rx_frame(input int budget, output logic [7:0] b, output int waited, output logic ok);
        logic [7:0] v;
        v = 8'h00;
        waited = 0;
        ok = 1'b1;
        b = 8'h00;
        while (serial_tx !== 1'b0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (serial_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (SYM / 2) @(negedge clk);
        if (serial_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (SYM) @(negedge clk);
            v[i] = serial_tx;
        end
        repeat (SYM) @(negedge clk);
        if (serial_tx !== 1'b1) ok = 1'b0;
        b = v;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (serial_tx !== 1'b1) begin
            errors++; $display("FAIL reset_serial_tx: got %b expected 1", serial_tx);
        end
        checks++;
        if (dut.fifo_rx_uart_i.empty_o !== 1'b1 || dut.fifo_rx_uart_i.wr_ptr !== 5'd0) begin
            errors++; $display("FAIL reset_rx_empty: got wr_ptr %0d expected 0", dut.fifo_rx_uart_i.wr_ptr);
        end
        checks++;
        if (dut.fifo_tx_uart_i.empty_o !== 1'b1 || dut.fifo_tx_uart_i.rd_ptr !== 5'd0) begin
            errors++; $display("FAIL reset_tx_empty: got rd_ptr %0d expected 0", dut.fifo_tx_uart_i.rd_ptr);
        end
        checks++;
        if (dut.uart_i.data_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_data_in_ready: got %b expected 1", dut.uart_i.data_in_ready);
        end
        checks++;
        if (dut.uart_i.data_out_valid !== 1'b0 || dut.sending !== 1'b0) begin
            errors++; $display("FAIL reset_valid_sending: got %b%b expected 00", dut.uart_i.data_out_valid, dut.sending);
        end
    endtask

    task automatic test_single_rx();
        int cnt0;
        cnt0 = rx_valid_cnt;
        send_rx_byte(8'hA5);
        checks++;
        if (rx_valid_cnt - cnt0 !== 1) begin
            errors++; $display("FAIL single_rx_valid_pulses: got %0d expected 1", rx_valid_cnt - cnt0);
        end
        checks++;
        if (dut.fifo_rx_uart_i.fifo_reg[0] !== 8'hA5) begin
            errors++; $display("FAIL single_rx_data: got %02h expected a5", dut.fifo_rx_uart_i.fifo_reg[0]);
        end
        checks++;
        if (dut.fifo_rx_uart_i.wr_ptr !== 5'd1) begin
            errors++; $display("FAIL single_rx_wr_ptr: got %0d expected 1", dut.fifo_rx_uart_i.wr_ptr);
        end
    endtask

    task automatic test_glitch();
        int cnt0;
        cnt0 = rx_valid_cnt;
        serial_rx = 1'b0;
        repeat (3) @(negedge clk);
        serial_rx = 1'b1;
        repeat (3 * SYM) @(negedge clk);
        checks++;
        if (rx_valid_cnt !== cnt0) begin
            errors++; $display("FAIL glitch_valid: got %0d pulses expected 0", rx_valid_cnt - cnt0);
        end
        checks++;
        if (dut.fifo_rx_uart_i.wr_ptr !== 5'd1 || dut.fifo_rx_uart_i.fifo_reg[0] !== 8'hA5) begin
            errors++; $display("FAIL glitch_fifo: got wr_ptr %0d expected 1", dut.fifo_rx_uart_i.wr_ptr);
        end
        checks++;
        if (dut.uart_i.rx_state_q !== RX_IDLE) begin
            errors++; $display("FAIL glitch_rx_state: got %0d expected %0d", dut.uart_i.rx_state_q, RX_IDLE);
        end
    endtask

    task automatic test_rx_overflow();
        int cnt0;
        do_reset();
        cnt0 = rx_valid_cnt;
        for (int i = 0; i < 20; i++) send_rx_byte(rx_vec(i));
        checks++;
        if (rx_valid_cnt - cnt0 !== 20) begin
            errors++; $display("FAIL overflow_valid_count: got %0d expected 20", rx_valid_cnt - cnt0);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (dut.fifo_rx_uart_i.fifo_reg[i] !== rx_vec(i)) begin
                errors++; $display("FAIL overflow_data[%0d]: got %02h expected %02h", i, dut.fifo_rx_uart_i.fifo_reg[i], rx_vec(i));
            end
        end
        checks++;
        if (dut.fifo_rx_uart_i.wr_ptr !== 5'd16 || dut.fifo_rx_uart_i.full_o !== 1'b1) begin
            errors++; $display("FAIL overflow_full: got wr_ptr %0d expected 16", dut.fifo_rx_uart_i.wr_ptr);
        end
    endtask

    task automatic drain_and_check(input string name, input int first, input int n, input int restart_at);
        logic [7:0] b;
        int waited;
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (i == restart_at) pulse_start();
            rx_frame(4 * SYM, b, waited, ok);
            checks++;
            if (!ok || b !== tx_vec(first + i)) begin
                errors++; $display("FAIL %s_byte[%0d]: got %02h ok=%b expected %02h", name, i, b, ok, tx_vec(first + i));
            end
            checks++;
            if ((i == 0 && waited > 3) || (i != 0 && waited > SYM / 2 + 3)) begin
                errors++; $display("FAIL %s_gap[%0d]: got %0d cycles expected at most %0d", name, i, waited, (i == 0) ? 3 : SYM / 2 + 3);
            end
        end
    endtask

    task automatic test_tx_drain();
        do_reset();
        preload_tx(0, 12);
        checks++;
        if (dut.fifo_tx_uart_i.wr_ptr !== 5'd12) begin
            errors++; $display("FAIL drain_preload: got wr_ptr %0d expected 12", dut.fifo_tx_uart_i.wr_ptr);
        end
        pulse_start();
        drain_and_check("drain", 0, 12, -1);
        repeat (5) @(negedge clk);
        checks++;
        if (dut.sending !== 1'b0 || dut.fifo_tx_uart_i.rd_ptr !== 5'd12) begin
            errors++; $display("FAIL drain_done: got sending %b rd_ptr %0d expected 0 12", dut.sending, dut.fifo_tx_uart_i.rd_ptr);
        end
    endtask

    task automatic test_tx_wrap();
        logic saw_low;
        preload_tx(12, 12);
        checks++;
        if (dut.fifo_tx_uart_i.wr_ptr !== 5'd24) begin
            errors++; $display("FAIL wrap_preload: got wr_ptr %0d expected 24", dut.fifo_tx_uart_i.wr_ptr);
        end
        pulse_start();
        drain_and_check("wrap", 12, 12, 5);
        saw_low = 1'b0;
        repeat (3 * SYM) begin
            @(negedge clk);
            if (serial_tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin
            errors++; $display("FAIL wrap_extra_frame: got line activity expected idle");
        end
        checks++;
        if (dut.sending !== 1'b0 || dut.fifo_tx_uart_i.rd_ptr !== 5'd24) begin
            errors++; $display("FAIL wrap_done: got sending %b rd_ptr %0d expected 0 24", dut.sending, dut.fifo_tx_uart_i.rd_ptr);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic saw_low;
        preload_tx(30, 2);
        pulse_start();
        repeat (3 * SYM) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (serial_tx !== 1'b1 || dut.uart_i.tx_state_q !== TX_IDLE) begin
            errors++; $display("FAIL midreset_line: got %b state %0d expected 1 idle", serial_tx, dut.uart_i.tx_state_q);
        end
        checks++;
        if (dut.sending !== 1'b0 || dut.fifo_tx_uart_i.wr_ptr !== 5'd0 || dut.uart_i.data_in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got sending %b wr_ptr %0d expected 0 0", dut.sending, dut.fifo_tx_uart_i.wr_ptr);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_low = 1'b0;
        repeat (4 * SYM) begin
            @(negedge clk);
            if (serial_tx !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low !== 1'b0) begin
            errors++; $display("FAIL midreset_resume: got line activity expected idle");
        end
    endtask

    initial begin
        force dut.tx_wr_en = force_en;
        force dut.tx_wr_data = force_data;
        test_reset();
        test_single_rx();
        test_glitch();
        test_rx_overflow();
        test_tx_drain();
        test_tx_wrap();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
